mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data word width; SHALL be a multiple of 8, minimum 16.
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter IND_DEPTH, default 1, number of pointer levels for indirect accesses; range 1..4.
REQ-004 Port list, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage instruction valid.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_ind  in  1  indirect access (LDI/STI class).
- req_byte  in  1  byte access; else full word.
- req_addr  in  ADDR_W  effective address from EX/MEM.
- req_wdata  in  DATA_W  store data; low byte is used for byte stores.
- dmem_resp  in  1  L1 data-cache response.
- dmem_rdata  in  DATA_W  L1 read data.
- dmem_read  out  1  cache read strobe.
- dmem_write  out  1  cache write strobe.
- dmem_addr  out  ADDR_W  cache address.
- dmem_wdata  out  DATA_W  cache write data.
- dmem_wmask  out  DATA_W/8  byte-enable mask.
- rsp_rdata  out  DATA_W  load result, zero-extended for byte loads.
- advance  out  1  1 = pipeline may load MEM/WB; 0 = stall.
- busy  out  1  FSM not in IDLE.

Function
REQ-005 FSM states SHALL be IDLE, PTR, ACCESS and DONE; a level counter lvl (0..IND_DEPTH-1) and a pointer register ptr (ADDR_W) SHALL be kept.
REQ-006 In IDLE, a request with no memory operation (req_valid=0, or req_read=0 and req_write=0) SHALL produce advance=1, with no strobes asserted, in the same cycle.
REQ-007 In IDLE, on req_valid with (req_read or req_write) and req_ind=0, the FSM SHALL go to ACCESS at the next edge.
- The address SHALL be req_addr.
REQ-008 In IDLE, on req_valid with req_ind=1, the FSM SHALL go to PTR at the next edge and set lvl=0.
- The PTR address SHALL be req_addr.
REQ-009 In PTR, dmem_read=1 and dmem_write=0 SHALL be driven.
- dmem_addr SHALL be req_addr when lvl=0, else ptr.
REQ-010 On dmem_resp in PTR, the block SHALL do all of the following:
- capture dmem_rdata[ADDR_W-1:0] into ptr;
- if lvl=IND_DEPTH-1, go to ACCESS;
- otherwise increment lvl and stay in PTR.
REQ-011 In ACCESS, dmem_addr SHALL be ptr for indirect requests and req_addr for direct requests.
- dmem_read SHALL equal req_read.
- dmem_write SHALL equal req_write.
REQ-012 On dmem_resp in ACCESS, the FSM SHALL go to DONE, and rsp_rdata SHALL be registered from dmem_rdata.
- Byte load: lane selected by addr[log2(DATA_W/8)-1:0], zero-extended.
REQ-013 In DONE, advance=1 and all strobes SHALL be 0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-014 advance SHALL be 0 in PTR and ACCESS regardless of dmem_resp.
REQ-015 Strobes and dmem_addr SHALL hold stable from the first cycle of PTR or ACCESS until dmem_resp.
REQ-016 dmem_wmask for a word store SHALL be all ones.
- For a byte store, only the bit indexed by the low address bits SHALL be set.
- For reads, the mask SHALL be all zeros.
REQ-017 dmem_wdata SHALL be req_wdata for a word store; for a byte store, req_wdata[7:0] SHALL be replicated in every byte lane.
REQ-018 Latency from IDLE to advance:
- direct access = 2 + (cycles waiting for dmem_resp in ACCESS);
- indirect access = 2 + IND_DEPTH + total response-wait cycles.
REQ-019 A request with both req_read and req_write set SHALL be treated as a write.
REQ-020 Request inputs SHALL be sampled combinationally every cycle; the upstream EX/MEM register SHALL hold them stable while advance=0.
REQ-021 dmem_resp in IDLE or DONE SHALL be ignored.
REQ-022 busy SHALL be 1 in PTR, ACCESS and DONE.

Reset
REQ-023 Asserting reset_n=0 SHALL, asynchronously and in any state including mid-access, force the following:
- FSM to IDLE;
- lvl=0, ptr=0, rsp_rdata=0;
- dmem_read=0, dmem_write=0, busy=0.
REQ-024 After release, the first request SHALL start from IDLE with no residual pointer state.

Verification
REQ-025 Direct word load: req_addr=0x1000, dmem_rdata=0xBEEF, dmem_resp after 3 cycles -> rsp_rdata=0xBEEF, then advance=1 for one cycle.
REQ-026 Byte store: req_addr=0x2003, req_wdata=0x12A5, DATA_W=16 -> dmem_wmask=2'b10, dmem_wdata=0xA5A5, dmem_write=1 until dmem_resp.
REQ-027 Indirect load with IND_DEPTH=2, as follows:
- stimulus: mem[0x3000]=0x4000, mem[0x4000]=0x5000, mem[0x5000]=0x00C3;
- required: read addresses 0x3000, then 0x4000, then 0x5000;
- required: rsp_rdata=0x00C3.
REQ-028 Byte load from an odd address: req_addr=0x0101, dmem_rdata=0x7F80 -> rsp_rdata=0x007F.
REQ-029 reset_n pulsed low during ACCESS with dmem_read=1 -> dmem_read drops immediately, busy=0, and a following direct load completes normally.
REQ-030 No-op instruction (req_read=0, req_write=0) -> advance=1 in the same cycle, with no strobes asserted.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer with multi-level pointer indirection.
// Request inputs are held by EX/MEM while advance=0, so they are decoded combinationally every cycle.
module mem_access_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int IND_DEPTH = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  input  logic                req_read,
  input  logic                req_write,
  input  logic                req_ind,
  input  logic                req_byte,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                dmem_resp,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_wmask,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                advance,
  output logic                busy
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int LVL_W  = (IND_DEPTH > 1) ? $clog2(IND_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                mem_op;
  logic                rd_eff;
  logic [ADDR_W-1:0]   acc_addr;
  logic [LANE_W-1:0]   lane;
  logic [NB-1:0]       byte_mask;
  logic [7:0]          byte_rd;
  logic [ADDR_W-1:0]   ptr_src;

  assign mem_op   = req_valid & (req_read | req_write);
  // Read+write together is a store; the read strobe is suppressed.
  assign rd_eff   = req_read & ~req_write;
  assign acc_addr = req_ind ? ptr_q : req_addr;
  assign lane     = acc_addr[LANE_W-1:0];

  generate
    if (ADDR_W <= DATA_W) begin : g_ptr_narrow
      assign ptr_src = dmem_rdata[ADDR_W-1:0];
    end else begin : g_ptr_wide
      assign ptr_src = {{(ADDR_W-DATA_W){1'b0}}, dmem_rdata};
    end
  endgenerate

  always_comb begin
    byte_mask = '0;
    byte_rd   = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (lane == LANE_W'(i)) begin
        byte_mask[i] = 1'b1;
        byte_rd      = dmem_rdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    dmem_addr  = req_addr;
    dmem_wdata = req_byte ? {NB{req_wdata[7:0]}} : req_wdata;
    dmem_wmask = '0;
    advance    = 1'b0;
    case (state_q)
      S_IDLE: advance = ~mem_op;
      S_PTR: begin
        dmem_read = 1'b1;
        dmem_addr = (lvl_q == '0) ? req_addr : ptr_q;
      end
      S_ACCESS: begin
        dmem_addr  = acc_addr;
        dmem_read  = rd_eff;
        dmem_write = req_write;
        if (req_write) dmem_wmask = req_byte ? byte_mask : '1;
      end
      S_DONE: advance = 1'b1;
      default: advance = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          lvl_d   = '0;
          state_d = req_ind ? S_PTR : S_ACCESS;
        end
      end
      S_PTR: begin
        if (dmem_resp) begin
          ptr_d = ptr_src;
          if (lvl_q == LVL_W'(IND_DEPTH - 1)) state_d = S_ACCESS;
          else                               lvl_d   = lvl_q + LVL_W'(1);
        end
      end
      S_ACCESS: begin
        if (dmem_resp) begin
          state_d = S_DONE;
          if (rd_eff) rdata_d = req_byte ? {{(DATA_W-8){1'b0}}, byte_rd} : dmem_rdata;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        lvl_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      lvl_q   <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized bench for mem_access_ctrl against a transaction-level memory model.
module tb_mem_access_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int IND = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic          req_ind = 1'b0, req_byte = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          dmem_resp = 1'b0;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_read, dmem_write;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [1:0]    dmem_wmask;
  logic [DW-1:0] rsp_rdata;
  logic          advance, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] mem [int];

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IND_DEPTH(IND)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_ind(req_ind), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .rsp_rdata(rsp_rdata),
    .advance(advance), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a ^ 16'h5A3C;
  endfunction

  task automatic mem_phase(input string tag, input logic [15:0] a, input logic e_rd, input logic e_wr,
                           input logic [1:0] e_mask, input logic [15:0] e_wd, input int w);
    for (int j = 0; j <= w; j++) begin
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
      #1;
      check({tag, "_read"}, dmem_read, e_rd);
      check({tag, "_write"}, dmem_write, e_wr);
      check({tag, "_addr"}, dmem_addr, a);
      check({tag, "_adv"}, advance, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      if (e_wr) begin
        check({tag, "_wmask"}, dmem_wmask, e_mask);
        check({tag, "_wdata"}, dmem_wdata, e_wd);
      end
      if (j == w) begin
        dmem_resp  = 1'b1;
        dmem_rdata = mem_rd(a);
      end
      @(posedge clk); #1;
    end
    dmem_resp = 1'b0;
  endtask

  task automatic run_req(input logic rd, input logic wr, input logic ind, input logic byt,
                         input logic [15:0] addr, input logic [15:0] wd, input int fw);
    logic [15:0] a;
    logic [15:0] pa[$];
    logic [15:0] word, e_wd, e_rsp;
    logic [1:0]  e_mask;
    logic        e_rd, lane;
    a = addr;
    pa = {};
    if (ind) begin
      for (int k = 0; k < IND; k++) begin
        pa.push_back(a);
        a = mem_rd(a);
      end
    end
    e_rd   = rd & ~wr;
    lane   = a[0];
    e_mask = wr ? (byt ? (lane ? 2'b10 : 2'b01) : 2'b11) : 2'b00;
    e_wd   = byt ? {wd[7:0], wd[7:0]} : wd;
    word   = mem_rd(a);
    e_rsp  = byt ? {8'h00, (lane ? word[15:8] : word[7:0])} : word;

    req_valid = 1'b1; req_read = rd; req_write = wr; req_ind = ind; req_byte = byt;
    req_addr = addr; req_wdata = wd;
    dmem_resp = 1'($urandom_range(0, 1));
    dmem_rdata = 16'($urandom);
    #1;
    check("idle_adv", advance, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_read", dmem_read, 1'b0);
    check("idle_write", dmem_write, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < pa.size(); k++)
      mem_phase("ptr", pa[k], 1'b1, 1'b0, 2'b00, e_wd, int'($urandom_range(0, 3)));
    mem_phase("acc", a, e_rd, wr, e_mask, e_wd, (fw < 0) ? int'($urandom_range(0, 3)) : fw);
    if (wr) begin
      if (!byt)     mem[int'(a)] = wd;
      else if (lane) mem[int'(a)] = {wd[7:0], word[7:0]};
      else           mem[int'(a)] = {word[15:8], wd[7:0]};
    end
    dmem_resp  = 1'($urandom_range(0, 1));
    dmem_rdata = 16'($urandom);
    #1;
    check("done_adv", advance, 1'b1);
    check("done_busy", busy, 1'b1);
    check("done_read", dmem_read, 1'b0);
    check("done_write", dmem_write, 1'b0);
    if (e_rd) check("done_rsp", rsp_rdata, e_rsp);
    req_valid = 1'b0;
    dmem_resp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_noop(input logic vld);
    req_valid = vld; req_read = 1'b0; req_write = 1'b0;
    req_ind = 1'($urandom_range(0, 1)); req_addr = 16'($urandom);
    dmem_resp = 1'($urandom_range(0, 1));
    #1;
    check("noop_adv", advance, 1'b1);
    check("noop_read", dmem_read, 1'b0);
    check("noop_write", dmem_write, 1'b0);
    check("noop_busy", busy, 1'b0);
    req_ind = 1'b0; dmem_resp = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic op_r, op_w;
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_read", dmem_read, 1'b0);
    check("rst_write", dmem_write, 1'b0);
    check("rst_rsp", rsp_rdata, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    run_noop(1'b1);
    run_noop(1'b0);

    mem[int'(16'h1000)] = 16'hBEEF;
    run_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000, 3);
    check("direct_load", rsp_rdata, 16'hBEEF);

    run_req(1'b0, 1'b1, 1'b0, 1'b1, 16'h2003, 16'h12A5, 2);

    mem[int'(16'h3000)] = 16'h4000;
    mem[int'(16'h4000)] = 16'h5000;
    mem[int'(16'h5000)] = 16'h00C3;
    run_req(1'b1, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000, -1);
    check("indirect_load", rsp_rdata, 16'h00C3);

    mem[int'(16'h0101)] = 16'h7F80;
    run_req(1'b1, 1'b0, 1'b0, 1'b1, 16'h0101, 16'h0000, 1);
    check("byte_load_odd", rsp_rdata, 16'h007F);

    mem[int'(16'h0400)] = 16'h1234;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_ind = 1'b0; req_byte = 1'b0;
    req_addr = 16'h0400; dmem_resp = 1'b0;
    @(posedge clk); #1;
    #1;
    check("pre_rst_read", dmem_read, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_rst_read", dmem_read, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_rsp", rsp_rdata, 16'h0000);
    #1 reset_n = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_adv", advance, 1'b1);
    run_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, 16'h0000, -1);
    check("post_rst_load", rsp_rdata, 16'h1234);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 5) == 0) run_noop(1'($urandom_range(0, 1)));
      op_r = 1'($urandom_range(0, 1));
      op_w = op_r ? 1'($urandom_range(0, 1)) : 1'b1;
      run_req(op_r, op_w, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              16'($urandom_range(0, 63)), 16'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
